// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the user-button conditioner.
package btn_pkg;

    // 2 s hold at 48 MHz
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES   = 480000;
    localparam int unsigned DEFAULT_LONG_PRESS_CYCLES = 96000000;

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        LONG_HELD
    } btn_state_t;

endpackage : btn_pkg

// File: rtl/btn_debounce.sv
// Synchronizes the raw button pin, normalizes polarity and filters bounce.
// rise_c/fall_c flag the cycle in which the filtered level is about to change,
// so downstream registered logic updates on the same edge as stable.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk48,
    input  logic rst,
    input  logic btn_raw,
    output logic stable,
    output logic rise_c,
    output logic fall_c
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             synced;
    logic             accept;

    // Two-flop synchronizer feeding a persistence counter.
    always_comb begin
        s1_d     = btn_raw;
        s2_d     = s1_q;
        synced   = s2_q ^ ACTIVE_LOW;
        stable_d = stable_q;
        cnt_d    = '0;
        accept   = 1'b0;
        if (synced != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                accept   = 1'b1;
                stable_d = synced;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Sync flops reset to the released pin level so reset never looks like a press.
    always_ff @(posedge clk48) begin
        if (rst) begin
            s1_q     <= ACTIVE_LOW;
            s2_q     <= ACTIVE_LOW;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;
    assign rise_c = accept & synced;
    assign fall_c = accept & ~synced;

endmodule : btn_debounce

// File: rtl/btn_conditioner.sv
// Turns the OrangeCrab user button into a debounced level plus one-cycle
// press, release, short-press and long-press events.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
    parameter bit          ACTIVE_LOW        = 1'b1
) (
    input  logic clk48,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_press,
    output logic long_press
);

    localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

    logic              stable;
    logic              rise_c;
    logic              fall_c;

    btn_state_t        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              short_q, short_d;
    logic              long_q, long_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_debounce (
        .clk48   (clk48),
        .rst     (rst),
        .btn_raw (btn_raw),
        .stable  (stable),
        .rise_c  (rise_c),
        .fall_c  (fall_c)
    );

    // Press/hold FSM; a release in the threshold cycle wins over long_press.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        short_d   = 1'b0;
        long_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise_c) begin
                    press_d = 1'b1;
                    hold_d  = '0;
                    state_d = PRESSED;
                end
            end
            PRESSED: begin
                if (fall_c) begin
                    release_d = 1'b1;
                    short_d   = 1'b1;
                    state_d   = IDLE;
                end else if (hold_q == HOLD_LAST) begin
                    long_d  = 1'b1;
                    state_d = LONG_HELD;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            LONG_HELD: begin
                // hold counter frozen here so long_press fires once per press
                if (fall_c) begin
                    release_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, hold counter and registered event pulses.
    always_ff @(posedge clk48) begin
        if (rst) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            press_q   <= press_d;
            release_q <= release_d;
            short_q   <= short_d;
            long_q    <= long_d;
        end
    end

    assign btn_level     = stable;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign short_press   = short_q;
    assign long_press    = long_q;

endmodule : btn_conditioner

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short debounce and hold times.
module tb_btn_conditioner;

    localparam int unsigned DEB  = 8;
    localparam int unsigned LONG = 64;

    logic clk48;
    logic rst;
    logic btn_raw;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic short_press;
    logic long_press;

    int vectors;
    int errors;

    btn_conditioner #(
        .DEBOUNCE_CYCLES   (DEB),
        .LONG_PRESS_CYCLES (LONG),
        .ACTIVE_LOW        (1'b1)
    ) dut (
        .clk48         (clk48),
        .rst           (rst),
        .btn_raw       (btn_raw),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .short_press   (short_press),
        .long_press    (long_press)
    );

    initial clk48 = 1'b0;
    always #5 clk48 = ~clk48;

    // Advance one active edge; outputs are then sampled 1 time unit later.
    task automatic tick();
        @(posedge clk48);
        #1;
    endtask

    // Stimulus only: reset with the button released.
    task automatic apply_reset();
        rst     = 1'b1;
        btn_raw = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_reset();
        int any_hi;
        rst     = 1'b1;
        btn_raw = 1'b1;
        repeat (3) tick();
        vectors++;
        if ({btn_level, press_pulse, release_pulse, short_press, long_press} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=00000",
                     {btn_level, press_pulse, release_pulse, short_press, long_press});
        end
        rst    = 1'b0;
        any_hi = 0;
        for (int n = 1; n <= 100; n++) begin
            tick();
            if ({btn_level, press_pulse, release_pulse, short_press, long_press} != 5'b0)
                any_hi++;
        end
        vectors++;
        if (any_hi !== 0) begin
            errors++;
            $display("FAIL idle_released cycles_with_output_high got=%0d exp=0", any_hi);
        end
    endtask

    task automatic test_clean_press();
        int press_cnt, press_at, level_at;
        apply_reset();
        btn_raw   = 1'b0;
        press_cnt = 0;
        press_at  = -1;
        level_at  = -1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (press_pulse === 1'b1) begin
                press_cnt++;
                if (press_at < 0) press_at = n;
            end
            if (btn_level === 1'b1 && level_at < 0) level_at = n;
        end
        vectors++;
        if (press_at !== 10) begin
            errors++;
            $display("FAIL clean_press_edge got=%0d exp=10", press_at);
        end
        vectors++;
        if (press_cnt !== 1) begin
            errors++;
            $display("FAIL clean_press_count got=%0d exp=1", press_cnt);
        end
        vectors++;
        if (level_at !== 10) begin
            errors++;
            $display("FAIL clean_level_edge got=%0d exp=10", level_at);
        end
    endtask

    task automatic test_bounce();
        int press_cnt, press_at, rel_cnt;
        apply_reset();
        press_cnt = 0;
        rel_cnt   = 0;
        press_at  = -1;
        for (int i = 0; i < 10; i++) begin
            btn_raw = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (3) begin
                tick();
                if (press_pulse === 1'b1) press_cnt++;
                if (release_pulse === 1'b1) rel_cnt++;
            end
        end
        btn_raw = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (press_pulse === 1'b1) begin
                press_cnt++;
                if (press_at < 0) press_at = n;
            end
            if (release_pulse === 1'b1) rel_cnt++;
        end
        vectors++;
        if (press_cnt !== 1) begin
            errors++;
            $display("FAIL bounce_press_count got=%0d exp=1", press_cnt);
        end
        vectors++;
        if (press_at !== 10) begin
            errors++;
            $display("FAIL bounce_press_edge got=%0d exp=10", press_at);
        end
        vectors++;
        if (rel_cnt !== 0) begin
            errors++;
            $display("FAIL bounce_release_count got=%0d exp=0", rel_cnt);
        end
    endtask

    task automatic test_short_press();
        bit found;
        int rel_at, short_at, rel_cnt, short_cnt, long_cnt, level_off_at;
        apply_reset();
        btn_raw = 1'b0;
        found   = 1'b0;
        for (int n = 1; n <= 20 && !found; n++) begin
            tick();
            if (press_pulse === 1'b1) found = 1'b1;
        end
        vectors++;
        if (found !== 1'b1) begin
            errors++;
            $display("FAIL short_press_setup press_seen=%0b exp=1", found);
        end
        long_cnt = 0;
        repeat (40) begin
            tick();
            if (long_press === 1'b1) long_cnt++;
        end
        btn_raw      = 1'b1;
        rel_at       = -1;
        short_at     = -1;
        level_off_at = -1;
        rel_cnt      = 0;
        short_cnt    = 0;
        for (int n = 1; n <= 30; n++) begin
            tick();
            if (release_pulse === 1'b1) begin
                rel_cnt++;
                if (rel_at < 0) rel_at = n;
            end
            if (short_press === 1'b1) begin
                short_cnt++;
                if (short_at < 0) short_at = n;
            end
            if (long_press === 1'b1) long_cnt++;
            if (btn_level === 1'b0 && level_off_at < 0) level_off_at = n;
        end
        vectors++;
        if (rel_at !== 10 || rel_cnt !== 1) begin
            errors++;
            $display("FAIL short_release edge=%0d count=%0d exp edge=10 count=1", rel_at, rel_cnt);
        end
        vectors++;
        if (short_at !== 10 || short_cnt !== 1) begin
            errors++;
            $display("FAIL short_pulse edge=%0d count=%0d exp edge=10 count=1", short_at, short_cnt);
        end
        vectors++;
        if (long_cnt !== 0) begin
            errors++;
            $display("FAIL short_no_long got=%0d exp=0", long_cnt);
        end
        vectors++;
        if (level_off_at !== 10) begin
            errors++;
            $display("FAIL short_level_fall got=%0d exp=10", level_off_at);
        end
    endtask

    task automatic test_long_press();
        bit found;
        int long_at, long_cnt, rel_at, rel_cnt, short_cnt;
        apply_reset();
        btn_raw = 1'b0;
        found   = 1'b0;
        for (int n = 1; n <= 20 && !found; n++) begin
            tick();
            if (press_pulse === 1'b1) found = 1'b1;
        end
        vectors++;
        if (found !== 1'b1) begin
            errors++;
            $display("FAIL long_press_setup press_seen=%0b exp=1", found);
        end
        long_at  = -1;
        long_cnt = 0;
        for (int n = 1; n <= 200; n++) begin
            tick();
            if (long_press === 1'b1) begin
                long_cnt++;
                if (long_at < 0) long_at = n;
            end
        end
        vectors++;
        if (long_at !== 64) begin
            errors++;
            $display("FAIL long_edge got=%0d exp=64", long_at);
        end
        vectors++;
        if (long_cnt !== 1) begin
            errors++;
            $display("FAIL long_count got=%0d exp=1", long_cnt);
        end
        btn_raw   = 1'b1;
        rel_at    = -1;
        rel_cnt   = 0;
        short_cnt = 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (release_pulse === 1'b1) begin
                rel_cnt++;
                if (rel_at < 0) rel_at = n;
            end
            if (short_press === 1'b1) short_cnt++;
        end
        vectors++;
        if (rel_at !== 10 || rel_cnt !== 1) begin
            errors++;
            $display("FAIL long_release edge=%0d count=%0d exp edge=10 count=1", rel_at, rel_cnt);
        end
        vectors++;
        if (short_cnt !== 0) begin
            errors++;
            $display("FAIL long_no_short got=%0d exp=0", short_cnt);
        end
    endtask

    task automatic test_reset_mid_press();
        bit found;
        int press_at, press_cnt, long_at, rel_cnt;
        apply_reset();
        btn_raw = 1'b0;
        found   = 1'b0;
        for (int n = 1; n <= 20 && !found; n++) begin
            tick();
            if (press_pulse === 1'b1) found = 1'b1;
        end
        vectors++;
        if (found !== 1'b1) begin
            errors++;
            $display("FAIL midrst_setup press_seen=%0b exp=1", found);
        end
        repeat (20) tick();
        rst = 1'b1;
        tick();
        vectors++;
        if ({btn_level, press_pulse, release_pulse, short_press, long_press} !== 5'b0) begin
            errors++;
            $display("FAIL midrst_outputs got=%b exp=00000",
                     {btn_level, press_pulse, release_pulse, short_press, long_press});
        end
        rst       = 1'b0;
        press_at  = -1;
        press_cnt = 0;
        long_at   = -1;
        rel_cnt   = 0;
        for (int n = 1; n <= 100; n++) begin
            tick();
            if (press_pulse === 1'b1) begin
                press_cnt++;
                if (press_at < 0) press_at = n;
            end
            if (long_press === 1'b1 && long_at < 0) long_at = n;
            if (release_pulse === 1'b1) rel_cnt++;
        end
        vectors++;
        if (press_at !== 10 || press_cnt !== 1) begin
            errors++;
            $display("FAIL midrst_repress edge=%0d count=%0d exp edge=10 count=1", press_at, press_cnt);
        end
        vectors++;
        if (long_at !== 74) begin
            errors++;
            $display("FAIL midrst_long_edge got=%0d exp=74", long_at);
        end
        vectors++;
        if (rel_cnt !== 0) begin
            errors++;
            $display("FAIL midrst_no_release got=%0d exp=0", rel_cnt);
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        rst     = 1'b1;
        btn_raw = 1'b1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_short_press();
        test_long_press();
        test_reset_mid_press();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule : tb_btn_conditioner
